// File: rtl/decode_stage.sv
// ============================================================================
// Module   : decode_stage
// Purpose  : Registered RV32I decode with valid/ready skid buffering and a
//            saturating illegal-instruction counter. Define DECODE_M_EXT_EN to
//            compile in M-extension (funct7=0000001) decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [XLEN-1:0]  pc_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  out_pc_o,
    output logic [4:0]       rs1_addr_o,
    output logic [4:0]       rs2_addr_o,
    output logic [4:0]       rd_addr_o,
    output logic [XLEN-1:0]  imm_o,
    output logic [3:0]       alu_op_o,
    output logic [1:0]       operand_a_sel_o,
    output logic             operand_b_sel_o,
    output logic [2:0]       fmt_o,
    output logic             is_load_o,
    output logic             is_store_o,
    output logic             is_branch_o,
    output logic             is_jump_o,
    output logic             reg_we_o,
    output logic             mdu_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] illegal_cnt_o
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu_op;
        logic [1:0]      a_sel;
        logic            b_sel;
        logic [2:0]      fmt;
        logic            is_load;
        logic            is_store;
        logic            is_branch;
        logic            is_jump;
        logic            reg_we;
        logic            mdu;
        logic            illegal;
    } bundle_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            shamt_hi;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    bundle_t         dec;

    bundle_t         out_q;
    bundle_t         skid_q;
    logic            out_valid;
    logic            skid_valid;
    logic [CNT_W-1:0] illegal_cnt;
    logic            accept;
    logic            out_fire;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    // instr[25] is shamt[5]: only a valid shift amount when XLEN is 64.
    assign shamt_hi = (XLEN == 32) ? instr_i[25] : 1'b0;

    assign imm_i = XLEN'($signed(instr_i[31:20]));
    assign imm_s = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
    assign imm_b = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({instr_i[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0}));

    always_comb begin
        dec       = '0;
        dec.pc    = pc_i;
        dec.rs1   = instr_i[19:15];
        dec.rs2   = instr_i[24:20];
        dec.rd    = instr_i[11:7];
        dec.fmt   = FMT_R;
        dec.b_sel = 1'b1;
        case (opcode)
            OPC_LUI: begin
                dec.fmt   = FMT_U;
                dec.imm   = imm_u;
                dec.a_sel = 2'd2;
            end
            OPC_AUIPC: begin
                dec.fmt   = FMT_U;
                dec.imm   = imm_u;
                dec.a_sel = 2'd1;
            end
            OPC_JAL: begin
                dec.fmt     = FMT_J;
                dec.imm     = imm_j;
                dec.a_sel   = 2'd1;
                dec.is_jump = 1'b1;
            end
            OPC_JALR: begin
                dec.fmt     = FMT_I;
                dec.imm     = imm_i;
                dec.is_jump = 1'b1;
            end
            OPC_BRANCH: begin
                dec.fmt       = FMT_B;
                dec.imm       = imm_b;
                dec.b_sel     = 1'b0;
                dec.alu_op    = {1'b0, funct3};
                dec.is_branch = 1'b1;
            end
            OPC_LOAD: begin
                dec.fmt     = FMT_I;
                dec.imm     = imm_i;
                dec.is_load = 1'b1;
            end
            OPC_STORE: begin
                dec.fmt      = FMT_S;
                dec.imm      = imm_s;
                dec.is_store = 1'b1;
            end
            OPC_OPIMM: begin
                dec.fmt = FMT_I;
                dec.imm = imm_i;
                if (funct3 == 3'b001) begin
                    dec.alu_op = {instr_i[30], funct3};
                    if ((instr_i[31:26] != 6'b000000) || shamt_hi)
                        dec.illegal = 1'b1;
                end else if (funct3 == 3'b101) begin
                    dec.alu_op = {instr_i[30], funct3};
                    if (((instr_i[31:26] != 6'b000000) && (instr_i[31:26] != 6'b010000)) || shamt_hi)
                        dec.illegal = 1'b1;
                end else begin
                    dec.alu_op = {1'b0, funct3};
                end
            end
            OPC_OP: begin
                dec.fmt    = FMT_R;
                dec.b_sel  = 1'b0;
                dec.alu_op = {instr_i[30], funct3};
                case (funct7)
                    7'h00: ;
                    7'h20: begin
                        if ((funct3 != 3'b000) && (funct3 != 3'b101))
                            dec.illegal = 1'b1;
                    end
                    7'h01: begin
`ifdef DECODE_M_EXT_EN
                        dec.mdu    = 1'b1;
                        dec.alu_op = {1'b0, funct3};
`else
                        dec.illegal = 1'b1;
`endif
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            default: begin
                dec.illegal = 1'b1;
                dec.b_sel   = 1'b0;
            end
        endcase

        if (instr_i[1:0] != 2'b11)
            dec.illegal = 1'b1;

        if (dec.illegal) begin
            dec.is_load   = 1'b0;
            dec.is_store  = 1'b0;
            dec.is_branch = 1'b0;
            dec.is_jump   = 1'b0;
        end

        dec.reg_we = ((dec.fmt == FMT_R) || (dec.fmt == FMT_I) ||
                      (dec.fmt == FMT_U) || (dec.fmt == FMT_J)) &&
                     (dec.rd != 5'd0) && !dec.illegal;
    end

    // Ready comes from registered state only, so no out_ready_i -> in_ready_o path.
    assign in_ready_o = ~skid_valid;
    assign accept     = in_valid_i & ~skid_valid;
    assign out_fire   = out_valid & out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q       <= '0;
            skid_q      <= '0;
            out_valid   <= 1'b0;
            skid_valid  <= 1'b0;
            illegal_cnt <= '0;
        end else begin
            if (out_fire && out_q.illegal && (illegal_cnt != {CNT_W{1'b1}}))
                illegal_cnt <= illegal_cnt + CNT_W'(1);

            if (flush_i) begin
                out_valid  <= 1'b0;
                skid_valid <= 1'b0;
            end else if (!out_valid || out_ready_i) begin
                if (skid_valid) begin
                    out_q      <= skid_q;
                    out_valid  <= 1'b1;
                    skid_valid <= 1'b0;
                end else if (accept) begin
                    out_q     <= dec;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (accept) begin
                skid_q     <= dec;
                skid_valid <= 1'b1;
            end
        end
    end

    assign out_valid_o     = out_valid;
    assign out_pc_o        = out_q.pc;
    assign rs1_addr_o      = out_q.rs1;
    assign rs2_addr_o      = out_q.rs2;
    assign rd_addr_o       = out_q.rd;
    assign imm_o           = out_q.imm;
    assign alu_op_o        = out_q.alu_op;
    assign operand_a_sel_o = out_q.a_sel;
    assign operand_b_sel_o = out_q.b_sel;
    assign fmt_o           = out_q.fmt;
    assign is_load_o       = out_q.is_load;
    assign is_store_o      = out_q.is_store;
    assign is_branch_o     = out_q.is_branch;
    assign is_jump_o       = out_q.is_jump;
    assign reg_we_o        = out_q.reg_we;
    assign mdu_o           = out_q.mdu;
    assign illegal_o       = out_q.illegal;
    assign illegal_cnt_o   = illegal_cnt;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ============================================================================
// Module   : tb_decode_stage
// Purpose  : Scoreboard bench for decode_stage with directed RV32I vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_decode_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [XLEN-1:0]  pc;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [4:0]       rs1, rs2, rd;
    logic [XLEN-1:0]  imm;
    logic [3:0]       alu_op;
    logic [1:0]       a_sel;
    logic             b_sel;
    logic [2:0]       fmt;
    logic             is_load, is_store, is_branch, is_jump, reg_we, mdu, illegal;
    logic [CNT_W-1:0] cnt;

    decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .flush_i         (flush),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .instr_i         (instr),
        .pc_i            (pc),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_pc_o        (out_pc),
        .rs1_addr_o      (rs1),
        .rs2_addr_o      (rs2),
        .rd_addr_o       (rd),
        .imm_o           (imm),
        .alu_op_o        (alu_op),
        .operand_a_sel_o (a_sel),
        .operand_b_sel_o (b_sel),
        .fmt_o           (fmt),
        .is_load_o       (is_load),
        .is_store_o      (is_store),
        .is_branch_o     (is_branch),
        .is_jump_o       (is_jump),
        .reg_we_o        (reg_we),
        .mdu_o           (mdu),
        .illegal_o       (illegal),
        .illegal_cnt_o   (cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [1:0]  asel;
        logic        bsel;
        logic [2:0]  fmt;
        logic        ld, st, br, jmp, we, mdu, ill;
    } bund_t;

    // mode 0: every field; 1: all but imm; 2: pc, register fields and flags only
    typedef struct packed {
        bund_t      b;
        logic [1:0] mode;
    } ent_t;

    ent_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] exp_cnt = '0;
    logic [31:0]      pc_ctr = 32'h0000_1000;

    function automatic bund_t mk(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdd,
                                 input logic [31:0] im, input logic [3:0] al, input logic [1:0] as,
                                 input logic bs, input logic [2:0] fm, input logic [6:0] flags);
        bund_t b;
        b      = '0;
        b.rs1  = r1;
        b.rs2  = r2;
        b.rd   = rdd;
        b.imm  = im;
        b.alu  = al;
        b.asel = as;
        b.bsel = bs;
        b.fmt  = fm;
        {b.ld, b.st, b.br, b.jmp, b.we, b.mdu, b.ill} = flags;
        return b;
    endfunction

    function automatic bund_t mask_of(input logic [1:0] mode);
        bund_t m;
        m = '1;
        if (mode != 2'd0) m.imm = '0;
        if (mode == 2'd2) begin
            m.alu  = '0;
            m.asel = '0;
            m.bsel = '0;
            m.fmt  = '0;
        end
        return m;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    // Monitor: sample at negedge; a handshake seen here completes at the next posedge.
    always @(negedge clk) begin
        ent_t  e;
        bund_t a;
        bund_t m;
        if (rst_n && out_valid && out_ready) begin
            a = '0;
            a.pc = out_pc; a.rs1 = rs1; a.rs2 = rs2; a.rd = rd; a.imm = imm;
            a.alu = alu_op; a.asel = a_sel; a.bsel = b_sel; a.fmt = fmt;
            {a.ld, a.st, a.br, a.jmp, a.we, a.mdu, a.ill} =
                {is_load, is_store, is_branch, is_jump, reg_we, mdu, illegal};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got_pc=%h exp=none", out_pc);
            end else begin
                e = sb.pop_front();
                m = mask_of(e.mode);
                if (((a ^ e.b) & m) != '0) begin
                    errors++;
                    $display("FAIL bundle pc=%h got=%h exp=%h mask=%h", e.b.pc, a, e.b, m);
                end
                if (e.b.ill && (exp_cnt != {CNT_W{1'b1}}))
                    exp_cnt = exp_cnt + CNT_W'(1);
            end
        end
    end

    task automatic send(input logic [31:0] ins, input bund_t e, input logic [1:0] mode);
        ent_t en;
        int   n;
        logic acc;
        in_valid = 1'b1;
        instr    = ins;
        pc       = pc_ctr;
        en.b     = e;
        en.b.pc  = pc_ctr;
        en.mode  = mode;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (acc) begin
            sb.push_back(en);
            pc_ctr = pc_ctr + 32'd4;
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout got=not_accepted exp=accepted instr=%h", ins);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got=%0d exp=0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [6:0] F_WE  = 7'b0000100;
    localparam logic [6:0] F_ILL = 7'b0000001;

    initial begin
        bund_t e_ill;
        bund_t e_addi;
        logic [31:0] pc_a;
        e_ill  = mk(5'd0, 5'd0, 5'd0, 32'h0, 4'd0, 2'd0, 1'b0, 3'd0, F_ILL);
        e_addi = mk(5'd0, 5'd31, 5'd1, 32'hFFFF_FFFF, 4'd0, 2'd0, 1'b1, 3'd1, F_WE);

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0; pc = '0; out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_imm",       imm,            32'd0);
        chk("rst_pc",        out_pc,         32'd0);
        chk("rst_cnt",       32'(cnt),       32'd0);
        chk("rst_reg_we",    32'(reg_we),    32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors at full throughput.
        send(32'hFFF00093, e_addi, 2'd0);
        send(32'hFE000EE3, mk(5'd0, 5'd0, 5'd29, 32'hFFFF_FFFC, 4'd0, 2'd0, 1'b0, 3'd3, 7'b0010000), 2'd0);
        send(32'h007302B3, mk(5'd6, 5'd7, 5'd5, 32'h0, 4'd0, 2'd0, 1'b0, 3'd0, F_WE), 2'd1);
        send(32'h407302B3, mk(5'd6, 5'd7, 5'd5, 32'h0, 4'd8, 2'd0, 1'b0, 3'd0, F_WE), 2'd1);
        send(32'h4035D513, mk(5'd11, 5'd3, 5'd10, 32'h403, 4'd13, 2'd0, 1'b1, 3'd1, F_WE), 2'd0);
        send(32'h40017093, mk(5'd2, 5'd0, 5'd1, 32'h400, 4'd7, 2'd0, 1'b1, 3'd1, F_WE), 2'd0);
        send(32'h12345137, mk(5'd8, 5'd3, 5'd2, 32'h1234_5000, 4'd0, 2'd2, 1'b1, 3'd4, F_WE), 2'd0);
        send(32'h80000197, mk(5'd0, 5'd0, 5'd3, 32'h8000_0000, 4'd0, 2'd1, 1'b1, 3'd4, F_WE), 2'd0);
        send(32'h008000EF, mk(5'd0, 5'd8, 5'd1, 32'h8, 4'd0, 2'd1, 1'b1, 3'd5, 7'b0001100), 2'd0);
        send(32'h00008067, mk(5'd1, 5'd0, 5'd0, 32'h0, 4'd0, 2'd0, 1'b1, 3'd1, 7'b0001000), 2'd0);
        send(32'hFF812283, mk(5'd2, 5'd24, 5'd5, 32'hFFFF_FFF8, 4'd0, 2'd0, 1'b1, 3'd1, 7'b1000100), 2'd0);
        send(32'h00512623, mk(5'd2, 5'd5, 5'd12, 32'd12, 4'd0, 2'd0, 1'b1, 3'd2, 7'b0100000), 2'd0);
        send(32'h00000000, e_ill, 2'd2);
        send(32'h02009093, mk(5'd1, 5'd0, 5'd1, 32'h0, 4'd0, 2'd0, 1'b0, 3'd0, F_ILL), 2'd2);
        send(32'h407342B3, mk(5'd6, 5'd7, 5'd5, 32'h0, 4'd0, 2'd0, 1'b0, 3'd0, F_ILL), 2'd2);
`ifdef DECODE_M_EXT_EN
        send(32'h022081B3, mk(5'd1, 5'd2, 5'd3, 32'h0, 4'd0, 2'd0, 1'b0, 3'd0, 7'b0000110), 2'd1);
`else
        send(32'h022081B3, mk(5'd1, 5'd2, 5'd3, 32'h0, 4'd0, 2'd0, 1'b0, 3'd0, F_ILL), 2'd2);
`endif
        drain();
        chk("cnt_model", 32'(cnt), 32'(exp_cnt));
`ifdef DECODE_M_EXT_EN
        chk("cnt_after_vectors", 32'(cnt), 32'd3);
`else
        chk("cnt_after_vectors", 32'(cnt), 32'd4);
`endif

        // Backpressure: A in OUT, B in SKID, C stalls until out_ready rises.
        out_ready = 1'b0;
        pc_a = pc_ctr;
        send(32'hFFF00093, e_addi, 2'd0);
        send(32'h007302B3, mk(5'd6, 5'd7, 5'd5, 32'h0, 4'd0, 2'd0, 1'b0, 3'd0, F_WE), 2'd1);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_out_pc_first", out_pc, pc_a);
        fork
            send(32'h4035D513, mk(5'd11, 5'd3, 5'd10, 32'h403, 4'd13, 2'd0, 1'b1, 3'd1, F_WE), 2'd0);
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("bp_hold_valid", 32'(out_valid), 32'd1);
                chk("bp_hold_pc",    out_pc,         pc_a);
                chk("bp_hold_imm",   imm,            32'hFFFF_FFFF);
                out_ready = 1'b1;
            end
        join
        drain();

        // Flush with both entries full and a same-cycle valid input.
        out_ready = 1'b0;
        send(32'hFFF00093, e_addi, 2'd0);
        send(32'hFE000EE3, mk(5'd0, 5'd0, 5'd29, 32'hFFFF_FFFC, 4'd0, 2'd0, 1'b0, 3'd3, 7'b0010000), 2'd0);
        flush = 1'b1; in_valid = 1'b1; instr = 32'h007302B3;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready",  32'(in_ready),  32'd1);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("flush_still_empty", 32'(out_valid), 32'd0);

        // Reset mid-operation discards everything and clears the counter.
        out_ready = 1'b0;
        send(32'h00000000, e_ill, 2'd2);
        send(32'h00000000, e_ill, 2'd2);
        rst_n = 1'b0;
        #1;
        sb.delete();
        exp_cnt = '0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        chk("midrst_cnt",       32'(cnt),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Counter: 0 -> 1, then saturate at all-ones.
        send(32'h00000000, e_ill, 2'd2);
        drain();
        chk("cnt_first", 32'(cnt), 32'd1);
        for (int i = 0; i < 65534; i++)
            send(32'h00000000, e_ill, 2'd2);
        drain();
        chk("cnt_full", 32'(cnt), 32'h0000_FFFF);
        send(32'h00000000, e_ill, 2'd2);
        drain();
        chk("cnt_saturated", 32'(cnt), 32'h0000_FFFF);
        chk("cnt_model_end", 32'(cnt), 32'(exp_cnt));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/decode_stage.md
# decode_stage

Registered RV32I instruction decode stage with valid/ready handshake on both sides, sitting between fetch and execute in the MCU pipeline. Decodes one instruction per cycle into register addresses, a fully sign-extended immediate, ALU control and operand selects. A two-entry skid buffer provides full throughput under backpressure, and a saturating counter records illegal encodings. Optional M-extension decode is compiled in by macro.

## Interface
- XLEN, 32: width of PC and immediate datapath; legal values 32 or 64.
- CNT_W, 16: width of the illegal-instruction counter.

- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  discard all buffered instructions
- in_valid_i  in  1  instruction valid from fetch
- in_ready_o  out  1  stage can accept
- instr_i  in  32  raw instruction
- pc_i  in  XLEN  PC of instr_i
- out_valid_o  out  1  decoded bundle valid
- out_ready_i  in  1  execute accepts bundle
- out_pc_o  out  XLEN  PC of bundle
- rs1_addr_o, rs2_addr_o, rd_addr_o  out  5 each  instr[19:15], [24:20], [11:7]
- imm_o  out  XLEN  sign-extended immediate
- alu_op_o  out  4  ALU operation
- operand_a_sel_o  out  2  0 rs1, 1 PC, 2 zero
- operand_b_sel_o  out  1  0 rs2, 1 imm
- fmt_o  out  3  0 R, 1 I, 2 S, 3 B, 4 U, 5 J
- is_load_o, is_store_o, is_branch_o, is_jump_o  out  1 each
- reg_we_o  out  1  writes rd
- mdu_o  out  1  multiply/divide op
- illegal_o  out  1  illegal encoding
- illegal_cnt_o  out  CNT_W  saturating illegal count

## Operation
- Opcodes (instr[6:0]): LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
- Immediates per RISC-V I/S/B/U/J formats, bit 31 sign-extended to XLEN; U = {instr[31:12],12'b0} sign-extended.
- alu_op_o: OP → {instr[30],funct3}; OP-IMM funct3 1/5 → {instr[30],funct3}, other OP-IMM → {0,funct3}; BRANCH → {0,funct3}; LOAD/STORE/LUI/AUIPC/JAL/JALR → 0 (add).
- operand_a_sel_o: AUIPC, JAL → 1; LUI → 2; else 0. operand_b_sel_o: 0 for R and B, 1 otherwise.
- JALR is I-format with is_jump_o=1; JAL is J-format with is_jump_o=1.
- reg_we_o = fmt in {R,I,U,J} and rd≠0 and not illegal.
- illegal_o when: instr[1:0]≠11; unknown opcode; OP funct7 not 0x00/0x20, or 0x20 with funct3∉{0,5}; slli funct7≠0; srli/srai funct7∉{0x00,0x20}; XLEN=32 and shift instr[25]=1. Illegal forces reg_we_o, is_load_o, is_store_o, is_branch_o, is_jump_o to 0.
- Buffer: output register (OUT) plus skid register (SKID). in_ready_o = ~SKID.valid. On accept: OUT loads when empty or out_ready_i=1, otherwise SKID loads. When OUT drains and SKID valid, SKID moves to OUT. Order strictly preserved.
- illegal_cnt_o increments by 1 on each out handshake with illegal_o=1; saturates at 2^CNT_W−1; not cleared by flush.

## Timing
- Latency 1 cycle from accept to out_valid_o; throughput 1/cycle with out_ready_i=1.
- Reset: out_valid_o=0, in_ready_o=1, all data outputs 0, illegal_cnt_o=0; reset mid-operation discards both entries immediately.
- flush_i: next cycle OUT and SKID invalid, in_ready_o=1; flush takes priority over a same-cycle accept (instruction dropped) and over a same-cycle out handshake (handshake completes, counter still updates).
- out_valid_o and bundle stable while out_valid_o=1 and out_ready_i=0.
- in_ready_o depends only on registered state (no combinational path from out_ready_i).

## Configuration
- DECODE_M_EXT_EN defined: OP with funct7=0000001 is legal, mdu_o=1, alu_op_o={0,funct3}, reg_we_o per rd.
- Undefined: mdu_o tied 0; funct7=0000001 encodings are illegal.

## Test plan
- 0xFFF00093 (addi x1,x0,-1) → next cycle imm_o=0xFFFFFFFF, rd=1, alu_op_o=0, b_sel=1, fmt=1, reg_we_o=1; with XLEN=64 imm_o=all ones.
- 0xFE000EE3 (beq x0,x0,-4) → imm_o=0xFFFFFFFC, fmt=3, is_branch_o=1, reg_we_o=0, b_sel=0.
- out_ready_i=0, three back-to-back valid instructions → first in OUT, second in SKID, in_ready_o=0 on third; raise out_ready_i → all three delivered in order, none lost.
- flush_i with in_valid_i=1 and both entries full → next cycle out_valid_o=0, in_ready_o=1, no instruction delivered.
- 0x00000000 → illegal_o=1, reg_we_o=0, illegal_cnt_o 0→1; preload to 0xFFFF, another illegal → stays 0xFFFF.
- 0x022081B3 (mul x3,x1,x2) → with DECODE_M_EXT_EN mdu_o=1, illegal_o=0, reg_we_o=1; without, illegal_o=1, mdu_o=0.
